// File: rtl/stream_upsizer_pkg.sv
// Shared stream utilities used by the width-conversion blocks.
// Provides the index-width helper used to size lane counters.
package stream_upsizer_pkg;

    // Bits needed to hold an index 0..n-1; never less than one bit.
    function automatic int lane_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream packer: collects RATIO narrow beats, little-endian,
// into one wide word and holds it under AXI-Stream valid/ready rules.
// Optional feature macro: STREAM_UPSIZER_LAST_EN adds in_last/out_last/out_keep
// so a packet end can close a word early at any lane.
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
`ifdef STREAM_UPSIZER_LAST_EN
    input  logic                      in_last,
    output logic                      out_last,
    output logic [RATIO-1:0]          out_keep,
`endif
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = lane_width(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0]    lane;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] merged;
    logic [RATIO-1:0]     keep_next;
    logic [31:0]          lane_base;
    logic                 end_lane;
    logic                 accept;
    logic                 complete;

    // The beat arriving now closes the word at the last lane, or early on a
    // packet end when that feature is built in.
`ifdef STREAM_UPSIZER_LAST_EN
    assign end_lane = (lane == LAST_LANE) || in_last;
`else
    assign end_lane = (lane == LAST_LANE);
`endif

    // Only a completing beat needs the output register, so that is the only
    // beat ever stalled; in_valid is deliberately kept out of this path.
    assign in_ready  = !reset && !(end_lane && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && end_lane;
    assign lane_base = 32'(lane) * 32'(IN_WIDTH);

    // Wide word as it would look with the current beat dropped into its lane;
    // lanes above the current one are always zero in the accumulator.
    always_comb begin
        merged = acc;
        merged[lane_base +: IN_WIDTH] = in_data;
        keep_next = '0;
        for (int k = 0; k < RATIO; k++) begin
            keep_next[k] = (LANE_W'(k) <= lane);
        end
    end

    // Lane counter and accumulator; cleared on completion so the next word
    // starts at lane 0 with empty upper lanes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= '0;
            acc  <= '0;
        end else if (accept) begin
            if (complete) begin
                lane <= '0;
                acc  <= '0;
            end else begin
                lane <= lane + 1'b1;
                acc[lane_base +: IN_WIDTH] <= in_data;
            end
        end
    end

    // Output register: a completing beat loads a new word (even while the old
    // one is being taken), otherwise the word holds until out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
            out_last  <= 1'b0;
            out_keep  <= '0;
`endif
        end else if (complete) begin
            out_data  <= merged;
            out_valid <= 1'b1;
`ifdef STREAM_UPSIZER_LAST_EN
            out_last  <= in_last;
            out_keep  <= keep_next;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef STREAM_UPSIZER_LAST_EN
    logic unused_keep;
    assign unused_keep = ^keep_next;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// Randomised and directed bench for stream_upsizer (IN_WIDTH=8, RATIO=4).
// The reference model keeps queues of expected wide words built from the
// accepted beats; STREAM_UPSIZER_LAST_EN adds the early-completion checks.
module tb_stream_upsizer;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef STREAM_UPSIZER_LAST_EN
    logic        in_last;
    logic        out_last;
    logic [3:0]  out_keep;
`endif

    int total;
    int bad;

    // Model state: partially built word and finished words awaiting output.
    logic [31:0] m_word;
    int          m_count;
    logic [31:0] exp_data[$];
    logic [3:0]  exp_keep[$];
    logic        exp_last[$];

    stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef STREAM_UPSIZER_LAST_EN
        .in_last   (in_last),
        .out_last  (out_last),
        .out_keep  (out_keep),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_model();
        m_word  = '0;
        m_count = 0;
        exp_data.delete();
        exp_keep.delete();
        exp_last.delete();
    endtask

    // One clock of stimulus: drive at the falling edge, check the settled
    // outputs against the model, then advance the model by the handshakes
    // that the coming rising edge will perform.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic ordy,
                               input logic lst, output logic accepted);
        logic use_last;
        logic exp_ready;
        logic [31:0] full_word;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
`ifdef STREAM_UPSIZER_LAST_EN
        in_last   = lst;
        use_last  = lst;
`else
        use_last  = 1'b0;
`endif
        #1;
        total++;
        if (out_valid !== (exp_data.size() != 0)) begin
            bad++;
            $display("[TB] FAIL out_valid: got %b expected %b", out_valid, exp_data.size() != 0);
        end
        if (exp_data.size() != 0) begin
            total++;
            if (out_data !== exp_data[0]) begin
                bad++;
                $display("[TB] FAIL out_data: got %h expected %h", out_data, exp_data[0]);
            end
`ifdef STREAM_UPSIZER_LAST_EN
            total++;
            if (out_keep !== exp_keep[0] || out_last !== exp_last[0]) begin
                bad++;
                $display("[TB] FAIL keep_last: got %b/%b expected %b/%b",
                         out_keep, out_last, exp_keep[0], exp_last[0]);
            end
`endif
        end
        exp_ready = !((exp_data.size() != 0) && !ordy && (m_count == 3 || use_last));
        total++;
        if (in_ready !== exp_ready) begin
            bad++;
            $display("[TB] FAIL in_ready: got %b expected %b", in_ready, exp_ready);
        end
        accepted = v && (in_ready === 1'b1);
        if (out_valid === 1'b1 && ordy && exp_data.size() != 0) begin
            void'(exp_data.pop_front());
            void'(exp_keep.pop_front());
            void'(exp_last.pop_front());
        end
        if (accepted) begin
            full_word = m_word;
            full_word[m_count*8 +: 8] = d;
            if (m_count == 3 || use_last) begin
                exp_data.push_back(full_word);
                exp_keep.push_back(4'((1 << (m_count + 1)) - 1));
                exp_last.push_back(use_last);
                m_word  = '0;
                m_count = 0;
            end else begin
                m_word  = full_word;
                m_count = m_count + 1;
            end
        end
    endtask

    // Hold reset for a cycle, check the forced-idle outputs, release it and
    // confirm the input side opens immediately.
    task automatic test_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: got v=%b d=%h r=%b expected 0/0/0",
                     out_valid, out_data, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", in_ready);
        end
    endtask

    // Four back-to-back beats with the sink always ready: no stalls, and the
    // word shows one cycle after the last beat.
    task automatic test_back_to_back();
        logic acc_flag;
        logic [7:0] beats[4];
        beats = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, beats[i], 1'b1, 1'b0, acc_flag);
            total++;
            if (acc_flag !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b_accept beat %0d: got %b expected 1", i, acc_flag);
            end
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc_flag);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin
            bad++;
            $display("[TB] FAIL b2b_word: got %b/%h expected 1/44332211", out_valid, out_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc_flag);
    endtask

    // Eight beats offered against a stalled sink that frees up at cycle 12.
    task automatic test_backpressure();
        logic acc_flag;
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while ((idx < 8 || exp_data.size() != 0) && cyc < 40) begin
            drive_cycle(idx < 8, 8'(idx + 1), cyc >= 12, 1'b0, acc_flag);
            if (idx == 7 && cyc < 12) begin
                total++;
                if (acc_flag !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL stall_last_beat: got accept %b expected 0", acc_flag);
                end
            end
            if (acc_flag) idx++;
            cyc++;
        end
        total++;
        if (idx != 8 || exp_data.size() != 0) begin
            bad++;
            $display("[TB] FAIL backpressure_drain: got beats=%0d pending=%0d expected 8/0",
                     idx, exp_data.size());
        end
    endtask

    // A reset in the middle of a word throws away its partial beats.
    task automatic test_mid_reset();
        logic acc_flag;
        drive_cycle(1'b1, 8'hAA, 1'b1, 1'b0, acc_flag);
        drive_cycle(1'b1, 8'hBB, 1'b1, 1'b0, acc_flag);
        test_reset();
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b1, 1'b0, acc_flag);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc_flag);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
            bad++;
            $display("[TB] FAIL mid_reset_word: got %b/%h expected 1/04030201", out_valid, out_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc_flag);
    endtask

    // Random valid/ready traffic, then a bounded drain of finished words.
    task automatic test_random();
        logic acc_flag;
        int cyc;
        for (int i = 0; i < 1000; i++) begin
            drive_cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, 1'b0, acc_flag);
        end
        cyc = 0;
        while (exp_data.size() != 0 && cyc < 20) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc_flag);
            cyc++;
        end
        total++;
        if (exp_data.size() != 0) begin
            bad++;
            $display("[TB] FAIL random_drain: got pending=%0d expected 0", exp_data.size());
        end
    endtask

`ifdef STREAM_UPSIZER_LAST_EN
    // A packet end on the second beat closes a half-filled word.
    task automatic test_last();
        logic acc_flag;
        test_reset();
        drive_cycle(1'b1, 8'h10, 1'b1, 1'b0, acc_flag);
        drive_cycle(1'b1, 8'h20, 1'b1, 1'b1, acc_flag);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc_flag);
        total++;
        if (out_data !== 32'h00002010 || out_keep !== 4'b0011 || out_last !== 1'b1) begin
            bad++;
            $display("[TB] FAIL last_word: got %h/%b/%b expected 00002010/0011/1",
                     out_data, out_keep, out_last);
        end
        for (int i = 0; i < 300; i++) begin
            drive_cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                        ($urandom % 5) == 0, acc_flag);
        end
    endtask
`endif

    // Run every scenario in order and report.
    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
        in_last   = 1'b0;
`endif
        clear_model();
        repeat (2) @(negedge clk);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef STREAM_UPSIZER_LAST_EN
        test_last();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
